// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter slice.
// Optional feature macro used by this slice: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   localparam int DEF_WORDS_PER_BLOCK = 8;
   localparam int DEF_ADDR_W          = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DONE  = 2'd2,
      WRITE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SRC_I = 2'd0,
      SRC_D = 2'd1,
      SRC_W = 2'd2
   } src_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection among store, D fill and I fill.
// Stores always win. With MEM_ARB_ROUND_ROBIN_EN defined, two competing
// fills alternate based on the last granted fill; otherwise D beats I.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_req,
   input  logic d_req,
   input  logic w_req,
   input  src_t last_fill,
   output logic valid,
   output src_t src
);

   // Choose one requester; source is only meaningful when valid is high
   always_comb begin
      valid = i_req | d_req | w_req;
      src   = SRC_I;
      if (w_req) begin
         src = SRC_W;
      end else if (d_req && i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         src = (last_fill == SRC_D) ? SRC_I : SRC_D;
`else
         src = SRC_D;
`endif
      end else if (d_req) begin
         src = SRC_D;
      end else begin
         src = SRC_I;
      end
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   logic unused_last_fill;
   assign unused_last_fill = ^last_fill;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined memory port between I-cache fills,
// D-cache fills and D-cache write-through stores, one grant at a time.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternating fill priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
   parameter int ADDR_W          = DEF_ADDR_W
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               i_miss_req,
   input  logic [ADDR_W-1:0]                  i_miss_addr,
   input  logic                               d_miss_req,
   input  logic [ADDR_W-1:0]                  d_miss_addr,
   input  logic                               d_wr_req,
   input  logic [ADDR_W-1:0]                  d_wr_addr,
   input  logic [15:0]                        d_wr_data,
   output logic                               mem_en,
   output logic                               mem_wr,
   output logic [ADDR_W-1:0]                  mem_addr,
   output logic [15:0]                        mem_wdata,
   input  logic [15:0]                        mem_rdata,
   input  logic                               mem_rvalid,
   output logic [15:0]                        fill_data,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
   output logic                               i_fill_we,
   output logic                               d_fill_we,
   output logic                               i_fill_done,
   output logic                               d_fill_done,
   output logic                               d_wr_ack,
   output logic                               busy
);

   localparam int WW = $clog2(WORDS_PER_BLOCK);
   localparam int CW = WW + 1;
   localparam logic [CW-1:0]     NUM_WORDS = CW'(WORDS_PER_BLOCK);
   localparam logic [CW-1:0]     LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

   state_t            state, next_state;
   src_t              grant, last_fill, pick_src;
   logic              pick_valid;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [CW-1:0]     issue_cnt, ret_cnt;
   logic              issuing, ret_accept;

   mem_arb_pick u_pick (
      .i_req     (i_miss_req),
      .d_req     (d_miss_req),
      .w_req     (d_wr_req),
      .last_fill (last_fill),
      .valid     (pick_valid),
      .src       (pick_src)
   );

   assign issuing    = (state == FILL) && (issue_cnt < NUM_WORDS);
   assign ret_accept = (state == FILL) && mem_rvalid && (ret_cnt < NUM_WORDS);

   // State register; reset abandons any fill in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Grant latch, address/data capture and the issue/return counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant     <= SRC_I;
         last_fill <= SRC_I;
         addr_q    <= '0;
         wdata_q   <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               issue_cnt <= '0;
               ret_cnt   <= '0;
               if (pick_valid) begin
                  grant <= pick_src;
                  if (pick_src == SRC_W) begin
                     addr_q  <= d_wr_addr;
                     wdata_q <= d_wr_data;
                  end else begin
                     addr_q    <= ((pick_src == SRC_D) ? d_miss_addr : i_miss_addr) & ~OFF_MASK;
                     last_fill <= pick_src;
                  end
               end
            end
            FILL: begin
               if (issuing) begin
                  issue_cnt <= issue_cnt + 1'b1;
               end
               if (ret_accept) begin
                  ret_cnt <= ret_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and all combinational outputs; everything idles at zero
   always_comb begin
      next_state  = state;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      fill_data   = '0;
      fill_word   = '0;
      i_fill_we   = 1'b0;
      d_fill_we   = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      d_wr_ack    = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               next_state = (pick_src == SRC_W) ? WRITE : FILL;
            end
         end
         FILL: begin
            if (issuing) begin
               mem_en   = 1'b1;
               mem_addr = addr_q + ADDR_W'({issue_cnt, 1'b0});
            end
            if (ret_accept) begin
               fill_data = mem_rdata;
               fill_word = ret_cnt[WW-1:0];
               i_fill_we = (grant == SRC_I);
               d_fill_we = (grant == SRC_D);
               if (ret_cnt == LAST_WORD) begin
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            i_fill_done = (grant == SRC_I);
            d_fill_done = (grant == SRC_D);
            next_state  = IDLE;
         end
         WRITE: begin
            mem_en     = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = addr_q;
            mem_wdata  = wdata_q;
            d_wr_ack   = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// 4-cycle-latency memory model. Honors MEM_ARB_ROUND_ROBIN_EN if defined.
module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
   logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0, d_wr_data = '0;
   logic        mem_en, mem_wr, mem_rvalid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

   logic        spur_v = 1'b0;
   logic [15:0] spur_d = '0;
   logic [3:0]  pv = 4'b0;
   logic [15:0] pd [0:3];

   int errors = 0;
   int checks = 0;

   logic [58:0] obs;
   logic [58:0] exp_v;

   mem_arbiter #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
      .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
      .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .fill_data(fill_data), .fill_word(fill_word),
      .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
      .d_wr_ack(d_wr_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   assign obs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word,
                 i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy};

   // Memory contents are a fixed scramble of the word address
   function automatic logic [15:0] mem_data(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC35A;
   endfunction

   // Memory model: reads return exactly 4 cycles after issue; ignores reset
   always @(posedge clk) begin
      pv    <= {pv[2:0], mem_en & ~mem_wr};
      pd[0] <= mem_data(mem_addr);
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
   end

   assign mem_rvalid = pv[3] | spur_v;
   assign mem_rdata  = spur_v ? spur_d : pd[3];

   function automatic logic [58:0] pk(input logic en, input logic wr, input logic [15:0] addr,
                                      input logic [15:0] wd, input logic [15:0] fd,
                                      input logic [2:0] fw, input logic iwe, input logic dwe,
                                      input logic idn, input logic ddn, input logic ack,
                                      input logic bsy);
      return {en, wr, addr, wd, fd, fw, iwe, dwe, idn, ddn, ack, bsy};
   endfunction

   // Expected outputs k cycles after a fill grant (grant cycle is k=0)
   function automatic logic [58:0] exp_fill(input int k, input logic is_d, input logic [15:0] base);
      logic        en, we, dn, bsy;
      logic [15:0] addr, fd;
      logic [2:0]  fw;
      en   = (k >= 1) && (k <= 8);
      we   = (k >= 5) && (k <= 12);
      dn   = (k == 13);
      bsy  = (k >= 1) && (k <= 13);
      addr = en ? base + 16'(2 * (k - 1)) : 16'h0000;
      fd   = we ? mem_data(base + 16'(2 * (k - 5))) : 16'h0000;
      fw   = we ? 3'(k - 5) : 3'd0;
      return pk(en, 1'b0, addr, 16'h0000, fd, fw, we & ~is_d, we & is_d,
                dn & ~is_d, dn & is_d, 1'b0, bsy);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      i_miss_req = 1'b1;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%h exp=%h", obs, 59'h0);
      end
      tick();
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_hold_req got=%h exp=%h", obs, 59'h0);
      end
      i_miss_req = 1'b0;
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_release_idle got=%h exp=%h", obs, 59'h0);
      end
   endtask

   task automatic test_i_fill();
      tick();
      i_miss_addr = 16'h1234;
      i_miss_req  = 1'b1;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL i_fill_grant got=%h exp=%h", obs, 59'h0);
      end
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b0, 16'h1230);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL i_fill k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      i_miss_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL i_fill_idle got=%h exp=%h", obs, 59'h0);
      end
   endtask

   task automatic test_priority();
      tick();
      d_miss_addr = 16'h0104;
      i_miss_addr = 16'h020A;
      d_miss_req  = 1'b1;
      i_miss_req  = 1'b1;
      #1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b1, 16'h0100);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL prio_d_first k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      d_miss_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL prio_gap got=%h exp=%h", obs, 59'h0);
      end
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b0, 16'h0200);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL prio_i_second k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      i_miss_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL prio_idle got=%h exp=%h", obs, 59'h0);
      end
   endtask

   task automatic test_store_first();
      tick();
      d_wr_addr   = 16'hABCD;
      d_wr_data   = 16'h5A5A;
      d_wr_req    = 1'b1;
      d_miss_addr = 16'h0046;
      d_miss_req  = 1'b1;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL store_grant got=%h exp=%h", obs, 59'h0);
      end
      tick();
      d_wr_addr = 16'h1111;
      d_wr_data = 16'h2222;
      #1;
      exp_v = pk(1'b1, 1'b1, 16'hABCD, 16'h5A5A, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("[TB] FAIL store_write got=%h exp=%h", obs, exp_v);
      end
      tick();
      d_wr_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL store_gap got=%h exp=%h", obs, 59'h0);
      end
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b1, 16'h0040);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL store_then_fill k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      d_miss_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL store_idle got=%h exp=%h", obs, 59'h0);
      end
   endtask

   // Last fill served was D, so round robin prefers I here; fixed picks D
   task automatic test_second_pair();
      logic        first_d;
      logic [15:0] first_base, second_base;
      first_d     = ~RR;
      first_base  = RR ? 16'h0500 : 16'h0400;
      second_base = RR ? 16'h0400 : 16'h0500;
      tick();
      d_miss_addr = 16'h0400;
      i_miss_addr = 16'h050E;
      d_miss_req  = 1'b1;
      i_miss_req  = 1'b1;
      #1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, first_d, first_base);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL pair2_first k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      if (first_d) d_miss_req = 1'b0;
      else i_miss_req = 1'b0;
      #1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, ~first_d, second_base);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL pair2_second k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      d_miss_req = 1'b0;
      i_miss_req = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL pair2_idle got=%h exp=%h", obs, 59'h0);
      end
   endtask

   task automatic test_reset_mid_fill();
      tick();
      i_miss_addr = 16'h2000;
      i_miss_req  = 1'b1;
      #1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b0, 16'h2000);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL midrst_pre k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL midrst_assert got=%h exp=%h", obs, 59'h0);
      end
      tick();
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL midrst_hold got=%h exp=%h", obs, 59'h0);
      end
      tick();
      rst_n      = 1'b1;
      i_miss_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_stale c=%0d got=%h exp=%h", c, obs, 59'h0);
         end
         tick();
      end
      i_miss_addr = 16'h3008;
      i_miss_req  = 1'b1;
      #1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         #1;
         exp_v = exp_fill(k, 1'b0, 16'h3000);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL midrst_refill k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      i_miss_req = 1'b0;
      #1;
   endtask

   task automatic test_addr_change();
      tick();
      i_miss_addr = 16'h0010;
      i_miss_req  = 1'b1;
      #1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         if (k == 1) i_miss_addr = 16'hFFFF;
         #1;
         exp_v = exp_fill(k, 1'b0, 16'h0010);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("[TB] FAIL addr_change k=%0d got=%h exp=%h", k, obs, exp_v);
         end
      end
      tick();
      i_miss_req = 1'b0;
      #1;
   endtask

   task automatic test_spurious();
      tick();
      spur_d = 16'hBEEF;
      spur_v = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL spurious c=%0d got=%h exp=%h", c, obs, 59'h0);
         end
         tick();
      end
      spur_v = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL spurious_after got=%h exp=%h", obs, 59'h0);
      end
   endtask

   initial begin
      $display("[TB] mem_arbiter bench, round robin = %0d", RR);
      test_reset();
      test_i_fill();
      test_priority();
      test_store_first();
      test_second_pair();
      test_reset_mid_fill();
      test_addr_change();
      test_spurious();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle memory controller that shares one unified, pipelined main-memory port between the instruction-cache miss path, the data-cache miss path and data-cache write-through stores of the 5-stage pipeline. It grants one requester at a time, sequences block fills word by word, and returns the data with a word index to the granted cache. The pipeline's stall logic treats any requester still waiting on its done/ack pulse as a stall source.

## Interface
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two, 2..16.
- ADDR_W, 16, byte-address width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_miss_req  in  1  I-cache fill request; level; held until i_fill_done.
- i_miss_addr  in  ADDR_W  I-cache miss byte address.
- d_miss_req  in  1  D-cache fill request; level; held until d_fill_done.
- d_miss_addr  in  ADDR_W  D-cache miss byte address.
- d_wr_req  in  1  D-cache store request; level; held until d_wr_ack.
- d_wr_addr  in  ADDR_W  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  ADDR_W  memory address; 0 when mem_en=0.
- mem_wdata  out  16  write data; 0 unless write.
- mem_rdata  in  16  read data.
- mem_rvalid  in  1  read data valid; responses return in issue order, one per cycle max.
- fill_data  out  16  fill word to the granted cache.
- fill_word  out  log2(WORDS_PER_BLOCK)  word index within the block.
- i_fill_we / d_fill_we  out  1  fill_data valid for the I/D cache.
- i_fill_done / d_fill_done  out  1  one-cycle pulse; fill complete.
- d_wr_ack  out  1  one-cycle pulse; store performed.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, FILL (issue+collect), DONE, WRITE.
- IDLE: pick one request. d_wr_req wins over fills. Between fills: D before I (fixed priority, see Configuration). Latch the granted source and block base = addr & ~(2*WORDS_PER_BLOCK-1). Go to FILL or WRITE.
- FILL: issue counter 0..WORDS_PER_BLOCK-1. One read per cycle, mem_addr = base + 2*issue_cnt, until all are issued. Return counter increments on each mem_rvalid. fill_data = mem_rdata, fill_word = return count, and the granted *_fill_we is asserted, all combinationally in the mem_rvalid cycle. After the last return, go to DONE.
- DONE: one cycle; pulse the granted *_fill_done. Go to IDLE. The requester drops its req at this edge, so IDLE never re-grants the same request.
- WRITE: one cycle. mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1. Go to IDLE.
- Request address and data changes after grant are ignored.
- A request arriving mid-operation waits in IDLE; nothing is preempted.
- mem_rvalid is ignored outside FILL and after the last expected return.
- Reset, including mid-fill: state IDLE, both counters and the grant cleared, all outputs 0. In-flight memory responses are dropped.

## Timing
- Grant in IDLE cycle T. First read issued in T+1, last in T+WORDS_PER_BLOCK.
- With memory latency L, returns are in T+1+L .. T+WORDS_PER_BLOCK+L, DONE is in T+WORDS_PER_BLOCK+L+1, and IDLE follows.
- Store: IDLE T, WRITE T+1 with ack, IDLE T+2.
- Minimum spacing between consecutive grants: one IDLE cycle.
- Every output is 0 in reset and in IDLE, except busy, which is also 0 in IDLE.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, store > D fill > I fill.
- MEM_ARB_ROUND_ROBIN_EN defined: stores still win. When both fills are pending, grant the one not granted last; a last-fill flop resets to I, so D goes first. A single pending fill is granted regardless.

## Structure
- Package mem_arb_pkg: state enum (IDLE, FILL, DONE, WRITE), grant-source enum (SRC_I, SRC_D, SRC_W), WORDS_PER_BLOCK default.
- Sub-module mem_arb_pick: combinational grant selection from the three reqs plus the last-fill flop. Outputs valid and source.

## Test plan
- Reset then I miss at 0x1234, memory latency 4: reads issued to 0x1230..0x123E in cycles T+1..T+8. i_fill_we with fill_word 0..7 in T+5..T+12, i_fill_done in T+13.
- I and D miss in the same cycle: D served first, then I.
  - With MEM_ARB_ROUND_ROBIN_EN, a second simultaneous pair grants I.
- Store pending with a D miss: store at 0xABCD with data 0x5A5A completes first (mem_wr=1, ack the next cycle), then the fill starts.
- rst_n asserted after the 3rd return of a fill: all outputs 0 immediately, no done pulse, late mem_rvalid ignored. A new I miss after reset fills correctly.
- Miss address changed to 0xFFFF one cycle after grant of 0x0010: fill still reads 0x0010..0x001E.
- Spurious mem_rvalid in IDLE: no fill_we, state unchanged.
